jtdd_romarb: RTL and testbench
==============================

// Module: jtdd_romarb
// PURPOSE
//  Shares one 16-bit SDRAM read port between three 8-bit ROM requesters:
//  main CPU (slot 0), sound CPU (slot 1) and MCU (slot 2). Each slot has a
//  one-word cache, so sequential byte reads within a word hit without an
//  SDRAM access. Sits between the CPU subsystems and the SDRAM controller.
// PARAMETERS
//  AW0       18        main ROM byte-address width
//  AW1       15        sound ROM byte-address width
//  AW2       14        MCU ROM byte-address width
//  SDRAM_AW  22        SDRAM word-address width
//  OFFSET1   22'h2_0000  word offset of sound ROM in SDRAM (main ROM at 0)
//  OFFSET2   22'h2_4000  word offset of MCU ROM in SDRAM
// PORTS
//  clk        in   1         system clock
//  rst        in   1         synchronous reset, active high
//  main_cs    in   1         main ROM read request (level)
//  main_addr  in   AW0       main byte address
//  main_data  out  8         main read data
//  main_ok    out  1         main_data valid for main_addr
//  snd_cs/snd_addr[AW1]/snd_data[8]/snd_ok   same roles, slot 1
//  mcu_cs/mcu_addr[AW2]/mcu_data[8]/mcu_ok   same roles, slot 2
//  sdram_req  out  1         read request to SDRAM controller
//  sdram_addr out  SDRAM_AW  word address of request
//  sdram_ack  in   1         controller accepted request (1-cycle pulse)
//  sdram_rdy  in   1         sdram_dout valid (1-cycle pulse)
//  sdram_dout in   16        read word; low byte = even address
// BEHAVIOUR
//  - Cache per slot: word address tag, 16-bit data, valid bit.
//  - hit_i = cs_i & valid_i & (tag_i == addr_i[AW-1:1]). Combinational.
//  - x_ok = hit_i. x_data = addr_i[0] ? word[15:8] : word[7:0]. Both are
//    combinational from registered cache state.
//  - pend_i = cs_i & ~hit_i.
//  - Word address: slot0 = addr>>1; slot1 = OFFSET1 + (addr>>1);
//    slot2 = OFFSET2 + (addr>>1). Zero-extended to SDRAM_AW; no overflow check.
//  - FSM states:
//    IDLE: if any pend_i, grant by round robin starting at slot
//      (last+1) mod 3. Latch grant and request tag. Drive sdram_addr and
//      sdram_req<=1. Go to WAIT_ACK.
//    WAIT_ACK: hold req and addr until sdram_ack. On ack, req<=0 and go to
//      WAIT_DATA. If ack and rdy arrive together, fill the cache and go to IDLE.
//    WAIT_DATA: on sdram_rdy, write the granted slot: tag<=latched tag,
//      data<=dout, valid<=1. Set last<=grant and go to IDLE.
//  - Latency on a miss: cs sampled at edge N, so sdram_req is high after
//    edge N. x_ok rises in the cycle after the edge that samples sdram_rdy.
//  - A fetch is never aborted. If cs drops or addr changes mid-fetch, the fill
//    still completes with the latched tag; a new address then misses and
//    triggers a fresh fetch.
//  - One outstanding SDRAM request at a time. Ungranted slots wait; their
//    ok stays low unless they hit.
//  - Reset: state=IDLE, sdram_req=0, sdram_addr=0, every valid=0, last=2
//    (main gets first grant). All x_ok=0 after reset. x_data is don't-care
//    while ok=0.
// TESTING
//  1. Reset, then main_cs=1, addr=18'h00010. Expect sdram_req the next cycle
//     with addr 22'h8. Ack, then rdy with dout=16'hBEEF -> main_ok=1,
//     main_data=8'hEF.
//  2. After test 1, switch main_addr to 18'h00011. Expect main_ok=1 in the
//     same cycle, data=8'hBE, and no sdram_req.
//  3. main, snd and mcu all miss at the same edge. Expect grants in order
//     main, snd, mcu. Each sdram_req is issued only after the previous rdy.
//     snd word addr = 22'h20000 + (snd_addr>>1).
//  4. Controller pulses ack and rdy in the same cycle. Expect the cache
//     filled and the FSM back in IDLE after that edge, with no WAIT_DATA stall.
//  5. main_addr changes to 18'h00100 while in WAIT_DATA. The old fill
//     completes and main_ok stays 0. A second request is issued for 22'h80.
//  6. Assert rst during WAIT_ACK. The next cycle sdram_req=0, all ok=0, and a
//     new cs issues a fresh request.

Source files
------------

// File: rtl/jtdd_romarb.sv
// Three 8-bit ROM readers share one 16-bit SDRAM read port; each slot keeps a one-word cache.
// A miss reaches sdram_req one edge after cs; ok follows the rdy edge. Losing slots hold ok low until served.
module jtdd_romarb #(
    parameter int                AW0      = 18,
    parameter int                AW1      = 15,
    parameter int                AW2      = 14,
    parameter int                SDRAM_AW = 22,
    parameter logic [SDRAM_AW-1:0] OFFSET1 = 22'h2_0000,
    parameter logic [SDRAM_AW-1:0] OFFSET2 = 22'h2_4000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                main_cs,
    input  logic [AW0-1:0]      main_addr,
    output logic [7:0]          main_data,
    output logic                main_ok,
    input  logic                snd_cs,
    input  logic [AW1-1:0]      snd_addr,
    output logic [7:0]          snd_data,
    output logic                snd_ok,
    input  logic                mcu_cs,
    input  logic [AW2-1:0]      mcu_addr,
    output logic [7:0]          mcu_data,
    output logic                mcu_ok,
    output logic                sdram_req,
    output logic [SDRAM_AW-1:0] sdram_addr,
    input  logic                sdram_ack,
    input  logic                sdram_rdy,
    input  logic [15:0]         sdram_dout
);

    localparam int MAXAW = (AW0 > AW1) ? ((AW0 > AW2) ? AW0 : AW2)
                                       : ((AW1 > AW2) ? AW1 : AW2);
    localparam int TW = MAXAW - 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ACK  = 2'd1,
        WAIT_DATA = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [AW0-2:0]      tag0;
    logic [AW1-2:0]      tag1;
    logic [AW2-2:0]      tag2;
    logic [15:0]         word0, word1, word2;
    logic [2:0]          valid;
    logic [1:0]          last, grant, grant_nxt;
    logic [TW-1:0]       lat_tag, lat_tag_nxt;
    logic                req_nxt;
    logic [SDRAM_AW-1:0] addr_nxt;
    logic                fill;

    logic [2:0]          hit, pend;
    logic [SDRAM_AW-1:0] waddr0, waddr1, waddr2, sel_waddr;
    logic [TW-1:0]       sel_tag;
    logic [1:0]          pick, rr_s;
    logic                any_pend;

    assign hit[0] = main_cs & valid[0] & (tag0 == main_addr[AW0-1:1]);
    assign hit[1] = snd_cs  & valid[1] & (tag1 == snd_addr[AW1-1:1]);
    assign hit[2] = mcu_cs  & valid[2] & (tag2 == mcu_addr[AW2-1:1]);
    assign pend   = {mcu_cs, snd_cs, main_cs} & ~hit;

    assign main_ok   = hit[0];
    assign snd_ok    = hit[1];
    assign mcu_ok    = hit[2];
    assign main_data = main_addr[0] ? word0[15:8] : word0[7:0];
    assign snd_data  = snd_addr[0]  ? word1[15:8] : word1[7:0];
    assign mcu_data  = mcu_addr[0]  ? word2[15:8] : word2[7:0];

    assign waddr0 = SDRAM_AW'(main_addr[AW0-1:1]);
    assign waddr1 = OFFSET1 + SDRAM_AW'(snd_addr[AW1-1:1]);
    assign waddr2 = OFFSET2 + SDRAM_AW'(mcu_addr[AW2-1:1]);

    // Round robin: scan slots starting just after the last one served.
    always_comb begin
        pick     = 2'd0;
        any_pend = 1'b0;
        rr_s     = last;
        for (int k = 0; k < 3; k++) begin
            rr_s = (rr_s == 2'd2) ? 2'd0 : rr_s + 2'd1;
            if (!any_pend && pend[rr_s]) begin
                pick     = rr_s;
                any_pend = 1'b1;
            end
        end
    end

    always_comb begin
        sel_tag   = TW'(main_addr[AW0-1:1]);
        sel_waddr = waddr0;
        case (pick)
            2'd1: begin
                sel_tag   = TW'(snd_addr[AW1-1:1]);
                sel_waddr = waddr1;
            end
            2'd2: begin
                sel_tag   = TW'(mcu_addr[AW2-1:1]);
                sel_waddr = waddr2;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt   = state;
        req_nxt     = sdram_req;
        addr_nxt    = sdram_addr;
        grant_nxt   = grant;
        lat_tag_nxt = lat_tag;
        fill        = 1'b0;
        case (state)
            IDLE: begin
                if (any_pend) begin
                    grant_nxt   = pick;
                    lat_tag_nxt = sel_tag;
                    addr_nxt    = sel_waddr;
                    req_nxt     = 1'b1;
                    state_nxt   = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (sdram_ack) begin
                    req_nxt = 1'b0;
                    // A controller may return data in the same cycle it accepts.
                    if (sdram_rdy) begin
                        fill      = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = WAIT_DATA;
                    end
                end
            end
            WAIT_DATA: begin
                if (sdram_rdy) begin
                    fill      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sdram_req  <= 1'b0;
            sdram_addr <= '0;
            grant      <= 2'd0;
            lat_tag    <= '0;
            valid      <= 3'b000;
            last       <= 2'd2;
        end else begin
            state      <= state_nxt;
            sdram_req  <= req_nxt;
            sdram_addr <= addr_nxt;
            grant      <= grant_nxt;
            lat_tag    <= lat_tag_nxt;
            if (fill) begin
                valid[grant] <= 1'b1;
                last         <= grant;
            end
        end
    end

    // Tag and data need no reset: valid gates every use of them.
    always_ff @(posedge clk) begin
        if (fill) begin
            case (grant)
                2'd0: begin
                    tag0  <= lat_tag[AW0-2:0];
                    word0 <= sdram_dout;
                end
                2'd1: begin
                    tag1  <= lat_tag[AW1-2:0];
                    word1 <= sdram_dout;
                end
                default: begin
                    tag2  <= lat_tag[AW2-2:0];
                    word2 <= sdram_dout;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtdd_romarb.sv
// Bench for jtdd_romarb: directed scenarios then random traffic against a transaction-level cache model.
module tb_jtdd_romarb;

    logic        clk = 1'b0;
    logic        rst;
    logic        main_cs, snd_cs, mcu_cs;
    logic [17:0] main_addr;
    logic [14:0] snd_addr;
    logic [13:0] mcu_addr;
    logic [7:0]  main_data, snd_data, mcu_data;
    logic        main_ok, snd_ok, mcu_ok;
    logic        sdram_req;
    logic [21:0] sdram_addr;
    logic        sdram_ack, sdram_rdy;
    logic [15:0] sdram_dout;

    always #5 clk = ~clk;

    jtdd_romarb dut (
        .clk(clk), .rst(rst),
        .main_cs(main_cs), .main_addr(main_addr), .main_data(main_data), .main_ok(main_ok),
        .snd_cs(snd_cs), .snd_addr(snd_addr), .snd_data(snd_data), .snd_ok(snd_ok),
        .mcu_cs(mcu_cs), .mcu_addr(mcu_addr), .mcu_data(mcu_data), .mcu_ok(mcu_ok),
        .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_ack(sdram_ack),
        .sdram_rdy(sdram_rdy), .sdram_dout(sdram_dout)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Stimulus intent for the next edge.
    bit cs_v[3];
    int addr_v[3];
    bit n_ack, n_rdy, n_rst;
    int aw_mask[3] = '{32'h3FFFF, 32'h7FFF, 32'h3FFF};

    // Reference model: per-slot cached word, and the single outstanding fetch.
    bit          mv[3];
    int          mtag[3];
    logic [15:0] mword[3];
    int          m_last, m_grant, m_tag;
    bit          m_req, m_acc;
    logic [21:0] m_addr;

    function automatic logic [15:0] rom_word(input logic [21:0] a);
        if (a == 22'h8) return 16'hBEEF;
        return {a[7:0] ^ 8'h5A, a[15:8] ^ a[7:0] ^ 8'h3C};
    endfunction

    function automatic logic [21:0] word_addr(input int s, input int a);
        int w;
        w = a >> 1;
        if (s == 1) w += 32'h20000;
        if (s == 2) w += 32'h24000;
        return 22'(w);
    endfunction

    function automatic bit mhit(input int s);
        return cs_v[s] && mv[s] && (mtag[s] == (addr_v[s] >> 1));
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 3; s++) mv[s] = 1'b0;
        m_last = 2; m_grant = 0; m_tag = 0;
        m_req = 1'b0; m_acc = 1'b0; m_addr = '0;
    endtask

    task automatic check_outputs();
        logic [2:0] okb;
        logic [7:0] db[3];
        bit         eh;
        logic [7:0] eb;
        okb = {mcu_ok, snd_ok, main_ok};
        db[0] = main_data; db[1] = snd_data; db[2] = mcu_data;
        for (int s = 0; s < 3; s++) begin
            eh = mhit(s);
            chk($sformatf("ok%0d", s), 32'(okb[s]), 32'(eh));
            if (eh) begin
                eb = addr_v[s][0] ? mword[s][15:8] : mword[s][7:0];
                chk($sformatf("data%0d", s), 32'(db[s]), 32'(eb));
            end
        end
        chk("req", 32'(sdram_req), 32'(m_req));
        chk("addr", 32'(sdram_addr), 32'(m_addr));
    endtask

    // One clock: drive inputs, advance the model across the edge, check at the falling edge.
    task automatic tick();
        bit ack, rdy, found;
        int s;
        rst       = n_rst;
        main_cs   = cs_v[0]; main_addr = 18'(addr_v[0]);
        snd_cs    = cs_v[1]; snd_addr  = 15'(addr_v[1]);
        mcu_cs    = cs_v[2]; mcu_addr  = 14'(addr_v[2]);
        ack = n_ack && m_req;
        rdy = n_rdy && (m_acc || ack);
        sdram_ack  = ack;
        sdram_rdy  = rdy;
        sdram_dout = rdy ? rom_word(m_addr) : 16'($urandom);
        if (n_rst) begin
            model_reset();
        end else if (m_req || m_acc) begin
            if (ack) begin
                m_req = 1'b0;
                m_acc = 1'b1;
            end
            if (rdy) begin
                mv[m_grant]    = 1'b1;
                mtag[m_grant]  = m_tag;
                mword[m_grant] = rom_word(m_addr);
                m_last         = m_grant;
                m_acc          = 1'b0;
            end
        end else begin
            found = 1'b0;
            for (int k = 1; k <= 3; k++) begin
                s = (m_last + k) % 3;
                if (!found && cs_v[s] && !mhit(s)) begin
                    found   = 1'b1;
                    m_grant = s;
                    m_tag   = addr_v[s] >> 1;
                    m_addr  = word_addr(s, addr_v[s]);
                    m_req   = 1'b1;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic complete_fetch();
        n_ack = 1'b1; tick(); n_ack = 1'b0;
        n_rdy = 1'b1; tick(); n_rdy = 1'b0;
    endtask

    logic [21:0] t3_exp[3] = '{22'h20, 22'h20091, 22'h241FF};

    initial begin
        for (int s = 0; s < 3; s++) begin
            cs_v[s] = 1'b0; addr_v[s] = 0;
        end
        n_ack = 1'b0; n_rdy = 1'b0; n_rst = 1'b1;
        model_reset();
        rst = 1'b1; main_cs = 1'b0; snd_cs = 1'b0; mcu_cs = 1'b0;
        main_addr = '0; snd_addr = '0; mcu_addr = '0;
        sdram_ack = 1'b0; sdram_rdy = 1'b0; sdram_dout = '0;
        @(negedge clk);
        tick(); tick();
        n_rst = 1'b0;
        tick();
        chk("rst_req", 32'(sdram_req), 32'h0);
        chk("rst_addr", 32'(sdram_addr), 32'h0);

        // Miss, fetch, and fill with BEEF.
        cs_v[0] = 1'b1; addr_v[0] = 32'h10;
        tick();
        chk("t1_req", 32'(sdram_req), 32'h1);
        chk("t1_addr", 32'(sdram_addr), 32'h8);
        n_ack = 1'b1; tick(); n_ack = 1'b0;
        chk("t1_ok_early", 32'(main_ok), 32'h0);
        n_rdy = 1'b1; tick(); n_rdy = 1'b0;
        chk("t1_ok", 32'(main_ok), 32'h1);
        chk("t1_data", 32'(main_data), 32'hEF);

        // Odd byte of the same word hits combinationally.
        addr_v[0] = 32'h11;
        main_addr = 18'h11;
        #1;
        chk("t2_ok_same_cycle", 32'(main_ok), 32'h1);
        chk("t2_data", 32'(main_data), 32'hBE);
        tick();
        chk("t2_noreq", 32'(sdram_req), 32'h0);

        // All three miss together after a reset: main, snd, mcu in turn.
        n_rst = 1'b1; tick(); n_rst = 1'b0;
        cs_v[0] = 1'b1; addr_v[0] = 32'h40;
        cs_v[1] = 1'b1; addr_v[1] = 32'h123;
        cs_v[2] = 1'b1; addr_v[2] = 32'h3FF;
        for (int g = 0; g < 3; g++) begin
            tick();
            chk($sformatf("t3_req%0d", g), 32'(sdram_req), 32'h1);
            chk($sformatf("t3_addr%0d", g), 32'(sdram_addr), 32'(t3_exp[g]));
            n_ack = 1'b1; tick(); n_ack = 1'b0;
            tick();
            chk($sformatf("t3_wait%0d", g), 32'(sdram_req), 32'h0);
            n_rdy = 1'b1; tick(); n_rdy = 1'b0;
            chk($sformatf("t3_gap%0d", g), 32'(sdram_req), 32'h0);
        end
        chk("t3_all_ok", 32'({mcu_ok, snd_ok, main_ok}), 32'h7);

        // Ack and rdy in one cycle, then an immediate new request.
        addr_v[2] = 32'h2A0;
        tick();
        chk("t4_addr", 32'(sdram_addr), 32'h24150);
        n_ack = 1'b1; n_rdy = 1'b1; tick(); n_ack = 1'b0; n_rdy = 1'b0;
        chk("t4_ok", 32'(mcu_ok), 32'h1);
        chk("t4_idle", 32'(sdram_req), 32'h0);
        addr_v[1] = 32'h400;
        tick();
        chk("t4_next_req", 32'(sdram_req), 32'h1);
        chk("t4_next_addr", 32'(sdram_addr), 32'h20200);
        complete_fetch();

        // Address change while waiting for data.
        addr_v[0] = 32'h200;
        tick();
        chk("t5_addr", 32'(sdram_addr), 32'h100);
        n_ack = 1'b1; tick(); n_ack = 1'b0;
        addr_v[0] = 32'h100;
        n_rdy = 1'b1; tick(); n_rdy = 1'b0;
        chk("t5_stale_ok", 32'(main_ok), 32'h0);
        tick();
        chk("t5_refetch", 32'(sdram_req), 32'h1);
        chk("t5_refetch_addr", 32'(sdram_addr), 32'h80);
        complete_fetch();
        chk("t5_ok", 32'(main_ok), 32'h1);

        // Reset while waiting for ack.
        addr_v[0] = 32'h300;
        tick();
        chk("t6_req", 32'(sdram_req), 32'h1);
        n_rst = 1'b1; tick(); n_rst = 1'b0;
        chk("t6_req_clr", 32'(sdram_req), 32'h0);
        chk("t6_ok_clr", 32'({mcu_ok, snd_ok, main_ok}), 32'h0);
        tick();
        chk("t6_fresh", 32'(sdram_req), 32'h1);
        chk("t6_fresh_addr", 32'(sdram_addr), 32'h180);
        complete_fetch();

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            n_rst = ($urandom_range(0, 199) == 0);
            for (int s = 0; s < 3; s++) begin
                cs_v[s] = ($urandom_range(0, 9) < 7);
                if ($urandom_range(0, 3) == 0)
                    addr_v[s] = ($urandom_range(0, 15) + 16 * $urandom_range(0, 3)
                                 + 32'h1000 * $urandom_range(0, 1)) & aw_mask[s];
            end
            n_ack = ($urandom_range(0, 1) == 1);
            n_rdy = ($urandom_range(0, 2) != 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
